// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: arbitrates I-miss, D-miss and D write-through stores onto one memory port and sequences 8-word block fills
module cache_fill_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LAT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        d_wr_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_rdata,
  output logic [15:0] fill_data,
  output logic [15:0] fill_addr,
  output logic        i_write_data_array,
  output logic        i_write_tag_array,
  output logic        d_write_data_array,
  output logic        d_write_tag_array,
  output logic        busy
);
  // Word addressing assumes a 16-byte block (addr[3:1] = word) and a memory that answers at all
  if (BLOCK_WORDS != 8 || MEM_LAT < 1) begin : g_bad_cfg
    $error("cache_fill_arbiter supports BLOCK_WORDS=8 and MEM_LAT>=1 only");
  end

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL} state_t;

  state_t      r_state;
  logic        r_last_d;
  logic [3:0]  r_req_cnt;
  logic [3:0]  r_rcv_cnt;
  logic [15:0] r_base;

  logic w_idle, w_fill, w_store, w_issue, w_rcv, w_last, w_gnt_i, w_gnt_d, w_sel_i, w_sel_d;

  assign w_idle  = r_state == IDLE;
  assign w_fill  = !w_idle;
  assign w_sel_i = r_state == I_FILL;
  assign w_sel_d = r_state == D_FILL;
  assign w_store = w_idle && d_wr_req;
  assign w_gnt_i = w_idle && !d_wr_req && i_miss && (!d_miss || r_last_d);
  assign w_gnt_d = w_idle && !d_wr_req && d_miss && (!i_miss || !r_last_d);
  assign w_issue = w_fill && r_req_cnt < 4'(BLOCK_WORDS);
  assign w_rcv   = w_fill && mem_data_valid;
  assign w_last  = w_rcv && r_rcv_cnt == 4'(BLOCK_WORDS - 1);

  assign d_wr_ack           = w_store;
  assign mem_en             = w_store || w_issue;
  assign mem_wr             = w_store;
  assign mem_addr           = w_store ? d_wr_addr : w_issue ? r_base + {12'd0, r_req_cnt[2:0], 1'b0} : 16'd0;
  assign mem_wdata          = w_store ? d_wr_data : 16'd0;
  assign fill_data          = mem_rdata;
  assign fill_addr          = w_rcv ? r_base + {12'd0, r_rcv_cnt[2:0], 1'b0} : 16'd0;
  assign i_write_data_array = w_rcv && w_sel_i;
  assign i_write_tag_array  = w_last && w_sel_i;
  assign d_write_data_array = w_rcv && w_sel_d;
  assign d_write_tag_array  = w_last && w_sel_d;
  assign busy               = w_fill;

  // Grant a miss from IDLE, then count issued and received words until the last word lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_req_cnt <= 4'd0;
      r_rcv_cnt <= 4'd0;
      r_base    <= 16'd0;
    end else if (w_gnt_i || w_gnt_d) begin
      r_state   <= w_gnt_i ? I_FILL : D_FILL;
      r_last_d  <= w_gnt_d;
      r_base    <= (w_gnt_i ? i_miss_addr : d_miss_addr) & 16'hFFF0;
      r_req_cnt <= 4'd0;
      r_rcv_cnt <= 4'd0;
    end else begin
      if (w_issue) r_req_cnt <= r_req_cnt + 4'd1;
      if (w_rcv) r_rcv_cnt <= r_rcv_cnt + 4'd1;
      if (w_last) r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: directed tests of arbitration, block fills, stores and reset abort
module tb_cache_fill_arbiter;
  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, mem_en, mem_wr, mem_data_valid, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data, fill_addr;
  logic        i_write_data_array, i_write_tag_array, d_write_data_array, d_write_tag_array;
  logic        extra_v;
  logic [MEM_LAT-1:0] v;
  logic [15:0] a [MEM_LAT];
  int checks = 0;
  int errors = 0;

  cache_fill_arbiter #(.BLOCK_WORDS(8), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
    .fill_data(fill_data), .fill_addr(fill_addr),
    .i_write_data_array(i_write_data_array), .i_write_tag_array(i_write_tag_array),
    .d_write_data_array(d_write_data_array), .d_write_tag_array(d_write_tag_array),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: a read issued in cycle N returns ~address in cycle N+MEM_LAT
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      for (int i = 0; i < MEM_LAT; i++) a[i] <= 16'd0;
    end else begin
      v <= {v[MEM_LAT-2:0], mem_en & ~mem_wr};
      a[0] <= mem_addr;
      for (int i = 1; i < MEM_LAT; i++) a[i] <= a[i-1];
    end
  end
  assign mem_data_valid = v[MEM_LAT-1] | extra_v;
  assign mem_rdata      = ~a[MEM_LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks fill cycles T+1..T+12 from cycle T (the grant cycle), checking issue, receive and strobes
  task automatic run_fill(input bit is_i, input logic [15:0] base, input bit raise_wr, input bit drop);
    logic [15:0] ea, fa;
    logic sd, st;
    logic [1:0] oth;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (raise_wr && k == 1) begin d_wr_req = 1; d_wr_addr = 16'h4000; d_wr_data = 16'hBEEF; end
      if (drop && k == 2) begin i_miss = 0; d_miss = 0; end
      @(negedge clk);
      ea  = base + 16'(2 * (k - 1));
      fa  = base + 16'(2 * (k - 5));
      sd  = is_i ? i_write_data_array : d_write_data_array;
      st  = is_i ? i_write_tag_array : d_write_tag_array;
      oth = is_i ? {d_write_data_array, d_write_tag_array} : {i_write_data_array, i_write_tag_array};
      checks++;
      if (busy !== 1'b1 || d_wr_ack !== 1'b0) begin
        errors++; $display("FAIL fill_busy k=%0d busy=%b ack=%b want busy=1 ack=0", k, busy, d_wr_ack);
      end
      checks++;
      if (mem_en !== 1'(k <= 8)) begin
        errors++; $display("FAIL fill_mem_en k=%0d got %b want %b", k, mem_en, k <= 8);
      end
      if (k <= 8) begin
        checks++;
        if (mem_wr !== 1'b0 || mem_addr !== ea) begin
          errors++; $display("FAIL fill_issue k=%0d wr=%b addr=%h want wr=0 addr=%h", k, mem_wr, mem_addr, ea);
        end
      end
      checks++;
      if (sd !== 1'(k >= 5) || st !== 1'(k == 12) || oth !== 2'b00) begin
        errors++; $display("FAIL fill_strobes k=%0d data=%b tag=%b other=%b want data=%b tag=%b other=00", k, sd, st, oth, k >= 5, k == 12);
      end
      if (k >= 5) begin
        checks++;
        if (fill_addr !== fa || fill_data !== ~fa) begin
          errors++; $display("FAIL fill_word k=%0d fill_addr=%h fill_data=%h want %h %h", k, fill_addr, fill_data, fa, ~fa);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 0; i_miss = 0; d_miss = 0; d_wr_req = 0; extra_v = 0;
    i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({d_wr_ack, mem_en, mem_wr, busy, i_write_data_array, i_write_tag_array, d_write_data_array, d_write_tag_array} !== 8'd0
        || mem_addr !== 16'd0 || mem_wdata !== 16'd0 || fill_addr !== 16'd0 || fill_data !== mem_rdata) begin
      errors++; $display("FAIL reset_outputs en=%b busy=%b addr=%h wdata=%h fill_addr=%h want all 0", mem_en, busy, mem_addr, mem_wdata, fill_addr);
    end
    rst = 1;
    step();
    extra_v = 1;
    @(negedge clk);
    checks++;
    if ({busy, i_write_data_array, i_write_tag_array, d_write_data_array, d_write_tag_array} !== 5'd0 || fill_addr !== 16'd0) begin
      errors++; $display("FAIL idle_valid busy=%b strobes=%b%b%b%b fill_addr=%h want 0", busy, i_write_data_array, i_write_tag_array, d_write_data_array, d_write_tag_array, fill_addr);
    end
    step();
    extra_v = 0;
  endtask

  task automatic test_i_miss();
    i_miss = 1; i_miss_addr = 16'h1236;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL imiss_grant_cycle busy=%b en=%b want 0 0", busy, mem_en);
    end
    run_fill(1, 16'h1230, 0, 0);
    step();
    i_miss = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL imiss_done busy=%b en=%b want 0 0", busy, mem_en);
    end
    step();
  endtask

  task automatic test_tie();
    rst = 0;
    @(negedge clk);
    rst = 1;
    step();
    i_miss = 1; i_miss_addr = 16'h3456; d_miss = 1; d_miss_addr = 16'h789A;
    run_fill(0, 16'h7890, 0, 0);
    step();
    run_fill(1, 16'h3450, 0, 0);
    step();
    run_fill(0, 16'h7890, 0, 0);
    step();
    i_miss = 0; d_miss = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL tie_done busy=%b want 0", busy);
    end
    step();
  endtask

  task automatic test_wr_during_fill();
    d_miss = 1; d_miss_addr = 16'h5678;
    run_fill(0, 16'h5670, 1, 0);
    step();
    d_miss = 0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h4000 || mem_wdata !== 16'hBEEF || d_wr_ack !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL wr_after_fill en=%b wr=%b addr=%h wdata=%h ack=%b busy=%b want 1 1 4000 beef 1 0", mem_en, mem_wr, mem_addr, mem_wdata, d_wr_ack, busy);
    end
    step();
    d_wr_req = 0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || d_wr_ack !== 1'b0) begin
      errors++; $display("FAIL wr_released en=%b ack=%b want 0 0", mem_en, d_wr_ack);
    end
    step();
  endtask

  task automatic test_wr_and_miss();
    d_wr_req = 1; d_wr_addr = 16'h0102; d_wr_data = 16'h5A5A; i_miss = 1; i_miss_addr = 16'hABCD;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0102 || mem_wdata !== 16'h5A5A || d_wr_ack !== 1'b1) begin
      errors++; $display("FAIL wr_first en=%b wr=%b addr=%h wdata=%h ack=%b want 1 1 0102 5a5a 1", mem_en, mem_wr, mem_addr, mem_wdata, d_wr_ack);
    end
    step();
    d_wr_req = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL miss_after_wr busy=%b en=%b want 0 0", busy, mem_en);
    end
    run_fill(1, 16'hABC0, 0, 0);
    step();
    i_miss = 0;
    step();
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) begin
      d_wr_req = 1; d_wr_addr = 16'h4000 + 16'(2 * j); d_wr_data = 16'h1000 + 16'(j);
      @(negedge clk);
      checks++;
      if (d_wr_ack !== 1'b1 || mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h4000 + 16'(2 * j) || mem_wdata !== 16'h1000 + 16'(j)) begin
        errors++; $display("FAIL b2b_store j=%0d ack=%b en=%b wr=%b addr=%h wdata=%h", j, d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata);
      end
      step();
    end
    d_wr_req = 0;
    step();
  endtask

  task automatic test_reset_mid_fill();
    i_miss = 1; i_miss_addr = 16'h2224;
    for (int k = 1; k <= 7; k++) step();
    @(negedge clk);
    checks++;
    if (i_write_data_array !== 1'b1 || fill_addr !== 16'h2224) begin
      errors++; $display("FAIL third_word data=%b fill_addr=%h want 1 2224", i_write_data_array, fill_addr);
    end
    step();
    rst = 0;
    #1;
    checks++;
    if ({busy, mem_en, mem_wr, d_wr_ack, i_write_data_array, i_write_tag_array, d_write_data_array, d_write_tag_array} !== 8'd0 || fill_addr !== 16'd0 || mem_addr !== 16'd0) begin
      errors++; $display("FAIL abort_outputs busy=%b en=%b tag=%b fill_addr=%h addr=%h want 0", busy, mem_en, i_write_tag_array, fill_addr, mem_addr);
    end
    @(negedge clk);
    rst = 1;
    run_fill(1, 16'h2220, 0, 0);
    step();
    i_miss = 0;
    step();
  endtask

  task automatic test_drop_miss();
    i_miss = 1; i_miss_addr = 16'h0F0E;
    run_fill(1, 16'h0F00, 0, 1);
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL drop_done busy=%b en=%b want 0 0", busy, mem_en);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_i_miss();
    test_tie();
    test_wr_during_fill();
    test_wr_and_miss();
    test_back_to_back();
    test_reset_mid_fill();
    test_drop_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
